// File: rtl/add_sub4_if.sv
// rtl/add_sub4_if.sv - operand/result bundle for add_sub4; ovf exists only with ADD_SUB4_OVF_EN
interface add_sub4_if #(
  parameter int WIDTH = 4
);
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef ADD_SUB4_OVF_EN
  logic             ovf;
`endif

  modport master (
    output op, a, b, c_in,
`ifdef ADD_SUB4_OVF_EN
    input  ovf,
`endif
    input  sum, c_out
  );

  modport slave (
    input  op, a, b, c_in,
`ifdef ADD_SUB4_OVF_EN
    output ovf,
`endif
    output sum, c_out
  );
endinterface

// File: rtl/add_sub4.sv
// rtl/add_sub4.sv - registered ripple-carry adder/subtractor, one-cycle latency
// Optional signed-overflow output enabled by defining ADD_SUB4_OVF_EN.
module add_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  add_sub4_if.slave  bus
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;

  // Subtraction reuses the adder: a + ~b + ~c_in == a - b - c_in (mod 2^WIDTH).
  always_comb begin
    bx       = bus.b ^ {WIDTH{bus.op}};
    carry    = '0;
    carry[0] = bus.c_in ^ bus.op;
    sum_d    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]   = bus.a[i] ^ bx[i] ^ carry[i];
      carry[i+1] = (bus.a[i] & bx[i]) | (carry[i] & (bus.a[i] ^ bx[i]));
    end
    c_out_d = carry[WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

`ifdef ADD_SUB4_OVF_EN
  logic ovf_d, ovf_q;

  // Signed overflow: carries into and out of the sign bit disagree.
  assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_sub4.sv
// tb/tb_add_sub4.sv - randomized and directed scoreboard bench for add_sub4
module tb_add_sub4;
  localparam int W = 4;

  typedef struct packed {
    int           due;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;

  exp_t  exp_q[$];
  string name_q[$];

  add_sub4_if #(.WIDTH(W)) bus ();

  add_sub4 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic r, input logic op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t e;
    int ua, ub, sa, sb, ures, sres;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    e = '0;
    if (r) return e;
    if (op == 1'b0) begin
      ures    = ua + ub + int'(cin);
      sres    = sa + sb + int'(cin);
      e.c_out = (ures >= (1 << W));
    end else begin
      ures    = ua - ub - int'(cin);
      sres    = sa - sb - int'(cin);
      e.c_out = (ures >= 0);
    end
    e.sum = W'(ures);
    e.ovf = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic drive(input logic r, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = r;
    bus.op   = op;
    bus.a    = a;
    bus.b    = b;
    bus.c_in = cin;
    e        = model(r, op, a, b, cin);
    e.due    = cyc + 1;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    logic  ok;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        ok = (e.due == cyc) && (bus.sum === e.sum) && (bus.c_out === e.c_out);
`ifdef ADD_SUB4_OVF_EN
        ok = ok && (bus.ovf === e.ovf);
        if (!ok)
          $display("FAIL %s: got sum=%b c_out=%b ovf=%b, expected sum=%b c_out=%b ovf=%b (cycle %0d due %0d)",
                   nm, bus.sum, bus.c_out, bus.ovf, e.sum, e.c_out, e.ovf, cyc, e.due);
`else
        if (!ok)
          $display("FAIL %s: got sum=%b c_out=%b, expected sum=%b c_out=%b (cycle %0d due %0d)",
                   nm, bus.sum, bus.c_out, e.sum, e.c_out, cyc, e.due);
`endif
        if (ok) passed++;
      end
    end
  end

  initial begin : stimulus
    int idx;
    int wait_cyc;
    bus.op   = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.c_in = 1'b0;

    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "reset0");
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, "reset1");
    drive(1'b0, 1'b0, 4'd5, 4'd0, 1'b0, "add_5_0");
    drive(1'b0, 1'b1, 4'd5, 4'd3, 1'b0, "sub_5_3");
    drive(1'b0, 1'b1, 4'd5, 4'd7, 1'b0, "sub_5_7_borrow");
    drive(1'b0, 1'b0, 4'hF, 4'd1, 1'b0, "add_wrap");
    drive(1'b0, 1'b0, 4'd5, 4'd3, 1'b1, "add_5_3_cin_ovf");
    drive(1'b0, 1'b1, 4'h8, 4'd1, 1'b0, "sub_min_ovf");
    drive(1'b0, 1'b1, 4'd0, 4'd0, 1'b1, "sub_borrow_in");

    // Exhaustive back-to-back sweep with one reset dropped in mid-stream.
    idx = 0;
    for (int op = 0; op < 2; op++)
      for (int cin = 0; cin < 2; cin++)
        for (int a = 0; a < (1 << W); a++)
          for (int b = 0; b < (1 << W); b++) begin
            if (idx == 517)
              drive(1'b1, 1'(op), W'(a), W'(b), 1'(cin), "sweep_reset");
            drive(1'b0, 1'(op), W'(a), W'(b), 1'(cin), "sweep");
            idx++;
          end

    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 31) == 0), 1'($urandom), W'($urandom), W'($urandom),
            1'($urandom), "random");

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
